// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory data-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] BYTES_NONE = 4'd0;
  localparam logic [3:0] BYTES_B    = 4'd1;
  localparam logic [3:0] BYTES_H    = 4'd2;
  localparam logic [3:0] BYTES_W    = 4'd4;

  function automatic logic legal_bytes(input logic [3:0] bytes);
    return (bytes == BYTES_B) || (bytes == BYTES_H) || (bytes == BYTES_W);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the previous winner loses a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes reads and 1/2/4-byte writes from two requesters onto the
// memory's single data port: IDLE -> ACCESS -> RESP, one access per 3 cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_write,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][3:0]            req_bytes,
  input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
  output logic                       resp_valid,
  output logic                       resp_id,
  output logic [DATA_WIDTH-1:0]      resp_rdata,
  output logic                       resp_err,
  output logic [ADDR_WIDTH-1:0]      fetch_addr,
  input  logic [DATA_WIDTH-1:0]      fetched_data,
  output logic [ADDR_WIDTH-1:0]      write_addr,
  output logic [DATA_WIDTH-1:0]      write_data,
  output logic [3:0]                 bytes_to_write
);

  state_t                state, state_next;
  logic                  last_grant;
  logic [1:0]            grant;
  logic                  win_id;
  logic                  handshake;

  logic                  lat_id;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [3:0]            lat_bytes;
  logic [DATA_WIDTH-1:0] lat_wdata;

  rr_arbiter2 u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     ((state == IDLE) && !rst),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign win_id    = grant[1];
  assign handshake = |(req_valid & grant);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (handshake) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_bytes  <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      resp_valid <= (state == ACCESS);
      if ((state == IDLE) && handshake) begin
        last_grant <= win_id;
        lat_id     <= win_id;
        lat_write  <= req_write[win_id];
        lat_addr   <= req_addr[win_id];
        lat_bytes  <= req_bytes[win_id];
        lat_wdata  <= req_wdata[win_id];
      end
      if (state == ACCESS) begin
        resp_id    <= lat_id;
        resp_rdata <= lat_write ? '0 : fetched_data;
        resp_err   <= lat_write && !legal_bytes(lat_bytes);
      end
    end
  end

  assign fetch_addr = lat_addr;
  assign write_addr = lat_addr;
  assign write_data = lat_wdata;

  // Gated by rst so a reset landing in ACCESS suppresses the memory write.
  always_comb begin
    bytes_to_write = BYTES_NONE;
    if ((state == ACCESS) && !rst && lat_write && legal_bytes(lat_bytes))
      bytes_to_write = lat_bytes;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed little-endian memory model.
module tb_mem_port_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_write;
  logic [1:0][31:0]  req_addr;
  logic [1:0][3:0]   req_bytes;
  logic [1:0][31:0]  req_wdata;
  logic              resp_valid;
  logic              resp_id;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       fetch_addr;
  logic [31:0]       fetched_data;
  logic [31:0]       write_addr;
  logic [31:0]       write_data;
  logic [3:0]        bytes_to_write;

  int pass_cnt = 0;
  int total_cnt = 0;
  int nz_cnt = 0;
  int resp_cnt = 0;

  logic [7:0] mem [0:511];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_bytes      (req_bytes),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_id        (resp_id),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .fetch_addr     (fetch_addr),
    .fetched_data   (fetched_data),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .bytes_to_write (bytes_to_write)
  );

  // Memory model: combinational little-endian read, byte-strobed write at the edge.
  assign fetched_data = {mem[fetch_addr[8:0] + 9'd3], mem[fetch_addr[8:0] + 9'd2],
                         mem[fetch_addr[8:0] + 9'd1], mem[fetch_addr[8:0]]};

  always @(posedge clk) begin
    if (bytes_to_write != 4'd0)
      for (int unsigned i = 0; i < bytes_to_write; i++)
        mem[write_addr[8:0] + 9'(i)] <= write_data[8*i +: 8];
  end

  always @(negedge clk) begin
    if (bytes_to_write != 4'd0) nz_cnt++;
    if (resp_valid) resp_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  bytes;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  btw;
  } vec_t;

  vec_t vecs [15];

  task automatic run_vec(input int idx);
    vec_t v;
    int   nz0;
    bit   got;
    v   = vecs[idx];
    nz0 = nz_cnt;
    req_valid[v.port] = 1'b1;
    req_write[v.port] = v.wr;
    req_addr[v.port]  = v.addr;
    req_bytes[v.port] = v.bytes;
    req_wdata[v.port] = v.wdata;
    got = 1'b0;
    for (int unsigned c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[v.port]) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      chk($sformatf("v%0d_grant_timeout", idx), 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    chk($sformatf("v%0d_ready", idx), {30'd0, req_ready}, v.port ? 32'd2 : 32'd1);
    @(posedge clk);
    #1 req_valid[v.port] = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_access_no_resp", idx), {31'd0, resp_valid}, 32'd0);
    chk($sformatf("v%0d_bytes_to_write", idx), {28'd0, bytes_to_write}, {28'd0, v.btw});
    chk($sformatf("v%0d_write_addr", idx), write_addr, v.addr);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_resp_valid", idx), {31'd0, resp_valid}, 32'd1);
    chk($sformatf("v%0d_resp_id", idx), {31'd0, resp_id}, {31'd0, v.port});
    chk($sformatf("v%0d_resp_rdata", idx), resp_rdata, v.rdata);
    chk($sformatf("v%0d_resp_err", idx), {31'd0, resp_err}, {31'd0, v.err});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_write_cycles", idx), nz_cnt - nz0, (v.btw != 4'd0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int g, r, last_c, resp0, nz0;
    bit got;

    for (int unsigned i = 0; i < 512; i++) mem[i] = 8'(i);

    //          port  wr    addr      bytes  wdata          rdata          err   btw
    vecs[0]  = '{1'b0, 1'b1, 32'h104, 4'd4, 32'hdeadbeef, 32'h00000000, 1'b0, 4'd4};
    vecs[1]  = '{1'b0, 1'b0, 32'h104, 4'd0, 32'h0,        32'hdeadbeef, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 32'h104, 4'd2, 32'hb0bacafe, 32'h00000000, 1'b0, 4'd2};
    vecs[3]  = '{1'b0, 1'b0, 32'h104, 4'd0, 32'h0,        32'hdeadcafe, 1'b0, 4'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h104, 4'd0, 32'h0,        32'hdeadcafe, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'h100, 4'd4, 32'h00000000, 32'h00000000, 1'b0, 4'd4};
    vecs[6]  = '{1'b1, 1'b1, 32'h101, 4'd4, 32'haabbccdd, 32'h00000000, 1'b0, 4'd4};
    vecs[7]  = '{1'b0, 1'b0, 32'h100, 4'd0, 32'h0,        32'hbbccdd00, 1'b0, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 32'h10c, 4'd1, 32'h12345678, 32'h00000000, 1'b0, 4'd1};
    vecs[9]  = '{1'b0, 1'b0, 32'h10c, 4'd0, 32'h0,        32'h0f0e0d78, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 1'b1, 32'h110, 4'd3, 32'hffffffff, 32'h00000000, 1'b1, 4'd0};
    vecs[11] = '{1'b1, 1'b1, 32'h110, 4'd0, 32'hffffffff, 32'h00000000, 1'b1, 4'd0};
    vecs[12] = '{1'b1, 1'b1, 32'h110, 4'd8, 32'hffffffff, 32'h00000000, 1'b1, 4'd0};
    vecs[13] = '{1'b1, 1'b0, 32'h110, 4'd3, 32'h0,        32'h13121110, 1'b0, 4'd0};
    vecs[14] = '{1'b0, 1'b0, 32'h108, 4'd0, 32'h0,        32'h0b0a0908, 1'b0, 4'd0};

    rst       = 1'b1;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_bytes = '0;
    req_wdata = '0;

    // Reset state: no grant while rst is high even with both ports requesting.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_resp", {28'd0, resp_valid, resp_id, resp_err, 1'b0}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fetch_addr", fetch_addr, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_bytes", {28'd0, bytes_to_write}, 32'd0);

    // Arbitration: both valid from reset, port 0 first, then strict alternation.
    @(posedge clk);
    #1;
    rst          = 1'b0;
    req_write    = '0;
    req_addr[0]  = 32'h100;
    req_addr[1]  = 32'h104;
    req_valid    = 2'b11;
    g = 0; r = 0; last_c = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        chk($sformatf("arb_grant%0d", g), {30'd0, req_ready}, (g % 2 == 1) ? 32'd2 : 32'd1);
        if (g > 0) chk($sformatf("arb_gap%0d", g), c - last_c, 32'd3);
        last_c = c;
        g++;
      end
      if (resp_valid) begin
        chk($sformatf("arb_resp_id%0d", r), {31'd0, resp_id}, (r % 2 == 1) ? 32'd1 : 32'd0);
        chk($sformatf("arb_rdata%0d", r), resp_rdata, (r % 2 == 1) ? 32'h07060504 : 32'h03020100);
        r++;
      end
      @(posedge clk);
    end
    #1 req_valid = '0;
    chk("arb_grant_count", g, 32'd4);
    chk("arb_resp_count", r, 32'd4);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Reset during ACCESS of a write: no write, no response, outputs cleared.
    resp0 = resp_cnt;
    nz0   = nz_cnt;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h108;
    req_bytes[0] = 4'd4;
    req_wdata[0] = 32'h11223344;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int unsigned c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[0]) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("rstw_granted", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    @(negedge clk);
    chk("rstw_bytes_in_access", {28'd0, bytes_to_write}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_flags", {27'd0, resp_valid, resp_id, resp_err, req_ready}, 32'd0);
    chk("rstw_rdata", resp_rdata, 32'd0);
    chk("rstw_fetch_addr", fetch_addr, 32'd0);
    chk("rstw_write_addr", write_addr, 32'd0);
    chk("rstw_write_data", write_data, 32'd0);
    chk("rstw_bytes", {28'd0, bytes_to_write}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rstw_no_resp", resp_cnt - resp0, 32'd0);
    chk("rstw_no_write", nz_cnt - nz0, 32'd0);

    // Priority restarts at port 0 after reset, even though port 0 won last.
    req_write   = '0;
    req_addr[0] = 32'h108;
    req_addr[1] = 32'h100;
    req_valid   = 2'b11;
    @(negedge clk);
    chk("rstw_prio", {30'd0, req_ready}, 32'd1);
    req_valid = '0;
    @(posedge clk);
    #1;
    run_vec(14);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
